// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of a multiplexed seven-segment frame.
// Each grant lasts DWELL ticks of an internal free-running prescaler. The owner's
// frame is captured on the win and refreshed live while its request is held.
// Optional build macro SEG_BLANK_GAP_EN: on a handover to a different requester,
// blank the display (IDLE_PATTERN, no grant) for one tick period before capturing.
module seg_display_arbiter #(
  parameter int unsigned NUMCELLS = 4,
  parameter int unsigned NUMREQ = 3,
  parameter int unsigned PRESCALE = 1024,
  parameter int unsigned DWELL = 8,
  parameter logic [8*NUMCELLS-1:0] IDLE_PATTERN = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUMREQ-1:0]            req,
  input  logic [NUMREQ*8*NUMCELLS-1:0] frame_in,
  output logic [NUMREQ-1:0]            ack,
  output logic [NUMREQ-1:0]            grant,
  output logic [8*NUMCELLS-1:0]        cellvalout,
  output logic                         busy
);

  localparam int unsigned FW = 8 * NUMCELLS;
  localparam int unsigned RW = $clog2(NUMREQ);
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned DW = $clog2(DWELL) + 1;

`ifdef SEG_BLANK_GAP_EN
  typedef enum logic [1:0] {StIdle, StDwell, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDwell} state_e;
`endif

  state_e            state_q, state_d;
  logic [RW-1:0]     rr_q, rr_d;
  logic [RW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     pre_q;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [NUMREQ-1:0] grant_q, grant_d;
  logic [NUMREQ-1:0] ack_q, ack_d;
  logic [FW-1:0]     cell_q, cell_d;

  logic              tick;
  logic              dwell_end;
  logic              found;
  logic [RW-1:0]     winner;
  logic [RW-1:0]     idx;
  logic              do_capture;

  assign tick      = (pre_q == PW'(PRESCALE - 1));
  assign dwell_end = tick && (dwell_q == DW'(DWELL - 1));

  // Free-running dwell prescaler; deliberately not restarted by grants.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NUMREQ; k++) begin
      idx = RW'((32'(rr_q) + k) % NUMREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state and registered output logic.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    dwell_d    = dwell_q;
    grant_d    = grant_q;
    ack_d      = '0;
    cell_d     = cell_q;
    do_capture = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) do_capture = 1'b1;
      end
      StDwell: begin
        if (dwell_end) begin
          if (!found) begin
            state_d = StIdle;
            grant_d = '0;
          end
`ifdef SEG_BLANK_GAP_EN
          else if (winner != owner_q) begin
            state_d = StGap;
            grant_d = '0;
            cell_d  = IDLE_PATTERN;
          end
`endif
          else begin
            do_capture = 1'b1;
          end
        end else begin
          if (tick) dwell_d = dwell_q + 1'b1;
          // Live update: the owner keeps refreshing its frame while requesting.
          if (req[owner_q]) begin
            cell_d         = frame_in[32'(owner_q) * FW +: FW];
            ack_d[owner_q] = 1'b1;
          end
        end
      end
`ifdef SEG_BLANK_GAP_EN
      StGap: begin
        if (tick) begin
          if (found) do_capture = 1'b1;
          else       state_d    = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (do_capture) begin
      state_d       = StDwell;
      owner_d       = winner;
      rr_d          = (winner == RW'(NUMREQ - 1)) ? '0 : winner + 1'b1;
      dwell_d       = '0;
      grant_d       = '0;
      grant_d[winner] = 1'b1;
      ack_d[winner] = 1'b1;
      cell_d        = frame_in[32'(winner) * FW +: FW];
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      rr_q    <= '0;
      owner_q <= '0;
      dwell_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      cell_q  <= IDLE_PATTERN;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      dwell_q <= dwell_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      cell_q  <= cell_d;
    end
  end

  assign ack        = ack_q;
  assign grant      = grant_q;
  assign cellvalout = cell_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter (NUMREQ=3, PRESCALE=4, DWELL=2).
// A tick-level model predicts every output each cycle; directed scenarios add
// hand-computed literal expectations. Honours SEG_BLANK_GAP_EN like the design.
module tb_seg_display_arbiter;

  localparam int NREQ = 3;
  localparam int PRE  = 4;
  localparam int DWL  = 2;
  localparam int FW   = 32;
`ifdef SEG_BLANK_GAP_EN
  localparam int GAPN = PRE;
`else
  localparam int GAPN = 0;
`endif

  logic             clock;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [NREQ*FW-1:0] frame_in;
  logic [NREQ-1:0]  ack;
  logic [NREQ-1:0]  grant;
  logic [FW-1:0]    cellvalout;
  logic             busy;

  seg_display_arbiter #(
    .NUMCELLS    (4),
    .NUMREQ      (NREQ),
    .PRESCALE    (PRE),
    .DWELL       (DWL),
    .IDLE_PATTERN(32'h0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .frame_in  (frame_in),
    .ack       (ack),
    .grant     (grant),
    .cellvalout(cellvalout),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Model: 0 idle, 1 showing owner, 2 blanking gap.
  bit              m_valid = 1'b0;
  int              m_state, m_owner, m_rr, m_pre, m_left;
  logic [NREQ-1:0] m_ack;
  logic [FW-1:0]   m_cell;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int from);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(from + k) % NREQ]) return (from + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) if (g == (NREQ'(1) << i)) return i;
    return -1;
  endfunction

  task automatic take(input int w);
    m_state    = 1;
    m_owner    = w;
    m_rr       = (w + 1) % NREQ;
    m_left     = DWL;
    m_cell     = frame_in[w*FW +: FW];
    m_ack[w]   = 1'b1;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_update();
    int  w;
    bit  tk;
    if (reset) begin
      m_valid = 1'b1;
      m_state = 0; m_owner = -1; m_rr = 0; m_pre = 0; m_left = 0;
      m_ack = '0; m_cell = 32'h0;
      return;
    end
    if (!m_valid) return;
    tk    = (m_pre == PRE - 1);
    m_pre = (m_pre + 1) % PRE;
    m_ack = '0;
    w     = pick(req, m_rr);
    if (m_state == 0) begin
      if (w >= 0) take(w);
    end else if (m_state == 1) begin
      if (tk && m_left == 1) begin
        if (w < 0) begin
          m_state = 0; m_owner = -1;
        end
`ifdef SEG_BLANK_GAP_EN
        else if (w != m_owner) begin
          m_state = 2; m_owner = -1; m_cell = 32'h0;
        end
`endif
        else take(w);
      end else begin
        if (tk) m_left--;
        if (req[m_owner]) begin
          m_cell         = frame_in[m_owner*FW +: FW];
          m_ack[m_owner] = 1'b1;
        end
      end
    end else begin
      if (tk) begin
        if (w >= 0) take(w);
        else        m_state = 0;
      end
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] eg;
    eg = (m_state == 1) ? (NREQ'(1) << m_owner) : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("cellvalout", cellvalout, m_cell);
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("ack_nonowner", 32'(ack & ~grant), 32'h0);
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    cycle++;
    if (m_valid) compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int owners[$];
  int exp_order[4] = '{0, 2, 0, 2};
  int n;
  int gap;
  bit done;
  logic [NREQ-1:0] prev;

  initial begin
    reset = 1'b1;
    req = '0;
    frame_in = {32'h5B5B5B5B, 32'h06060606, 32'h3F065B4F};
    @(negedge clock);

    // Reset held two cycles, then idle for 20 cycles.
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_cell", cellvalout, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_grant", 32'(grant), 32'h0);
      chk("idle_cell", cellvalout, 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
    end

    // First capture from IDLE: one-edge latency.
    req = 3'b001;
    step();
    chk("cap_grant", 32'(grant), 32'h1);
    chk("cap_ack", 32'(ack), 32'h1);
    chk("cap_cell", cellvalout, 32'h3F065B4F);
    chk("cap_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 10; i++) step();
    req = '0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (!busy) done = 1'b1;
    end
    chk("idle_timeout", 32'(done), 32'h1);

    // Round robin between 0 and 2 starting from pointer 0.
    do_reset();
    req  = 3'b101;
    prev = '0;
    for (int i = 0; i < 60 && owners.size() < 4; i++) begin
      step();
      if (grant != prev && grant != '0) owners.push_back(onehot_idx(grant));
      prev = grant;
    end
    chk("rr_count", 32'(owners.size()), 32'd4);
    n = (owners.size() < 4) ? owners.size() : 4;
    for (int i = 0; i < n; i++) chk("rr_order", 32'(owners[i]), 32'(exp_order[i]));

    // Live update by owner 0 while requester 1 waits.
    do_reset();
    req = 3'b011;
    step();
    chk("live_grant0", 32'(grant), 32'h1);
    step();
    frame_in[31:0] = 32'h66666666;
    step();
    chk("live_cell", cellvalout, 32'h66666666);
    chk("live_ack", 32'(ack), 32'h1);
    chk("live_grant", 32'(grant), 32'h1);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (grant != 3'b001 && grant != 3'b000) done = 1'b1;
    end
    chk("hand_timeout", 32'(done), 32'h1);
    chk("hand_grant", 32'(grant), 32'h2);
    chk("hand_cell", cellvalout, 32'h06060606);
    req = '0;
    for (int i = 0; i < 20; i++) step();

    // Owner drops request right after capture: full dwell still runs.
    do_reset();
    frame_in[31:0] = 32'h12345678;
    req = 3'b001;
    step();
    req = '0;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      n++;
      if (!busy) done = 1'b1;
    end
    chk("drop_len", 32'(n), 32'd7);
    chk("drop_grant", 32'(grant), 32'h0);
    chk("drop_busy", 32'(busy), 32'h0);
    chk("drop_cell", cellvalout, 32'h12345678);

    // Reset mid-dwell clears everything, including the round-robin pointer.
    req = 3'b010;
    step();
    step();
    chk("pre_rst_grant", 32'(grant), 32'h2);
    reset = 1'b1;
    step();
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_cell", cellvalout, 32'h0);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    reset = 1'b0;
    req = 3'b110;
    step();
    chk("post_rst_grant", 32'(grant), 32'h2);
    chk("post_rst_cell", cellvalout, 32'h06060606);

    // Handover 0 -> 1: blank gap only when the gap feature is built in.
    do_reset();
    req = 3'b011;
    step();
    gap = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (grant == '0) begin
        gap++;
        chk("gap_cell", cellvalout, 32'h0);
      end
      if (grant == 3'b010) done = 1'b1;
    end
    chk("gap_timeout", 32'(done), 32'h1);
    chk("gap_len", 32'(gap), 32'(GAPN));
    req = '0;
    for (int i = 0; i < 20; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the multiplexed NUMCELLS-digit seven-segment display among NUMREQ requesters. It uses round-robin arbitration with a minimum dwell time per grant. It drives the display mux's frame input (8 bits per cell, cell N-1 in the MSBs) and owns the only display register. Dwell time is timed by an internal tick prescaler, independent of the mux refresh rate.

Parameters:
NUMCELLS, 4, digits per frame; frame width FW = 8*NUMCELLS
NUMREQ, 3, number of requesters (>=2)
PRESCALE, 1024, clocks per dwell tick (>=2)
DWELL, 8, ticks per grant (>=1)
IDLE_PATTERN, 0, FW-bit frame shown after reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  NUMREQ  per-requester display request, level
frame_in  input  NUMREQ*FW  requester i frame at bits [FW*i +: FW]
ack  output  NUMREQ  one-cycle pulse: frame of requester i captured this edge
grant  output  NUMREQ  one-hot; current display owner; 0 when none
cellvalout  output  FW  frame to display mux, registered
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock is clock; reset is synchronous and active-high. The reset value of every register is applied at the first rising edge with reset=1.
- Reset values: ack=0, grant=0, cellvalout=IDLE_PATTERN, busy=0, state=IDLE, rr pointer=0, prescaler=0, dwell count=0.
- Prescaler: free-running 0..PRESCALE-1; tick=1 in the cycle the count equals PRESCALE-1; wraps to 0. It is not reset by grants. The first tick of a dwell may be partial: minimum dwell is (DWELL-1)*PRESCALE+1 clocks.
- Arbitration: the winner is the first i with req[i]=1, searching from the rr pointer upward, modulo NUMREQ. On a win, rr pointer <= (winner+1) mod NUMREQ.
- Capture: at the same edge as a win, grant <= onehot(winner), cellvalout <= frame_in[winner], ack[winner] <= 1, and dwell count <= 0.
- IDLE: if any req=1, win and capture, then go to DWELL. Latency is req high -> grant/ack/cellvalout valid after 1 edge. If no req, grant=0 and cellvalout holds its last value.
- DWELL: grant is held. Each tick increments the dwell count. While req[owner]=1, cellvalout <= frame_in[owner] every cycle, with ack[owner]=1 each such cycle (live update). Other requesters wait and get ack=0.
- Dwell end is the cycle with tick=1 and dwell count=DWELL-1:
  - if any req=1, arbitrate and capture at that edge and stay in DWELL (the same owner may win again only if it is the sole requester);
  - otherwise go to IDLE, grant <= 0, cellvalout holds.
- A req dropping mid-dwell does not shorten the dwell. Only the owner's updates stop.
- ack is at most one-hot and never asserted for a non-owner.
- Reset mid-dwell returns all registers to reset values at that edge. Any frame already on cellvalout is replaced by IDLE_PATTERN.

Optional Feature:
- Macro SEG_BLANK_GAP_EN.
- Defined: at dwell end, if the winner differs from the current owner, go to GAP instead of capturing. GAP sets grant=0, cellvalout=IDLE_PATTERN and busy=1. At the next tick, re-arbitrate from the current req: capture (DWELL) if any, else go to IDLE. The rr pointer advances only on an actual capture. Same-owner re-wins skip GAP.
- Undefined: the GAP state and its logic are absent; behaviour is as above.

Test Plan:
Bench parameters: NUMCELLS=4, NUMREQ=3, PRESCALE=4, DWELL=2, IDLE_PATTERN=0.
- Reset held 2 cycles, req=000 -> grant=000, ack=000, cellvalout=0x00000000, busy=0. This holds for 20 cycles after release.
- req=001, frame0=0x3F065B4F in IDLE -> next edge: grant=001, ack=001, cellvalout=0x3F065B4F, busy=1.
- From IDLE with rr=0, req=101 held -> owner order 0,2,0,2. Each handover lands exactly on a dwell-end tick; ack is never 100 while grant=001.
- Owner 0 changes frame0 to 0x66666666 mid-dwell while req1=1 -> cellvalout=0x66666666 next edge, ack=001, grant stays 001 until dwell end. Then grant=010 and cellvalout=frame1.
- Owner drops req at dwell start, no other req -> dwell completes. At dwell end grant=000, busy=0, cellvalout unchanged.
- Reset asserted mid-dwell -> at that edge grant=000, cellvalout=0, ack=000. The rr pointer returns to 0: with req=110 the next grant is 010.
- With SEG_BLANK_GAP_EN, owner 0 -> requester 1 handover -> one tick period of grant=000 and cellvalout=0. Then grant=010.
